// File: rtl/uart_rx.sv
// 8N1 UART receiver with run-time bit period, mid-bit sampling and a break lockout.
// A stop-bit error disarms start detection until the line has been seen idle high again.
module uart_rx (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_UART_RX,
  input  logic [15:0] i_ClksPerBit,
  input  logic        i_RxEn,
  output logic [7:0]  o_Data,
  output logic        o_Valid,
  output logic        o_FrameErr,
  output logic        o_Idle
);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t   state, state_nxt;
  logic        rx_meta, rx;
  logic [15:0] r_Cpb, cpb_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [2:0]  bit_idx, bit_idx_nxt;
  logic [7:0]  shift, shift_nxt;
  logic [7:0]  data_nxt;
  logic        armed, armed_nxt;
  logic        valid_nxt, ferr_nxt;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      rx_meta <= 1'b1;
      rx      <= 1'b1;
    end else begin
      rx_meta <= i_UART_RX;
      rx      <= rx_meta;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    cpb_nxt     = r_Cpb;
    armed_nxt   = armed;
    data_nxt    = o_Data;
    valid_nxt   = 1'b0;
    ferr_nxt    = 1'b0;
    case (state)
      RX_IDLE: begin
        cnt_nxt     = 16'd0;
        bit_idx_nxt = 3'd0;
        if (rx) armed_nxt = 1'b1;
        if (i_RxEn && armed && !rx) begin
          cpb_nxt   = i_ClksPerBit;
          state_nxt = RX_START;
        end
      end
      RX_START: begin
        // Half a bit in: a high line here means the falling edge was a glitch.
        if (cnt == (r_Cpb >> 1) - 16'd1) begin
          cnt_nxt   = 16'd0;
          state_nxt = rx ? RX_IDLE : RX_DATA;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      RX_DATA: begin
        if (cnt == r_Cpb - 16'd1) begin
          shift_nxt[bit_idx] = rx;
          cnt_nxt            = 16'd0;
          if (bit_idx == 3'd7) begin
            bit_idx_nxt = 3'd0;
            state_nxt   = RX_STOP;
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
          end
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      RX_STOP: begin
        // Leave at mid-stop-bit so a start bit right behind it is not missed.
        if (cnt == r_Cpb - 16'd1) begin
          if (rx) begin
            data_nxt  = shift;
            valid_nxt = 1'b1;
          end else begin
            ferr_nxt  = 1'b1;
            armed_nxt = 1'b0;
          end
          cnt_nxt   = 16'd0;
          state_nxt = RX_IDLE;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      default: state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state      <= RX_IDLE;
      cnt        <= 16'd0;
      bit_idx    <= 3'd0;
      shift      <= 8'h00;
      r_Cpb      <= 16'd0;
      armed      <= 1'b1;
      o_Data     <= 8'h00;
      o_Valid    <= 1'b0;
      o_FrameErr <= 1'b0;
      o_Idle     <= 1'b1;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      bit_idx    <= bit_idx_nxt;
      shift      <= shift_nxt;
      r_Cpb      <= cpb_nxt;
      armed      <= armed_nxt;
      o_Data     <= data_nxt;
      o_Valid    <= valid_nxt;
      o_FrameErr <= ferr_nxt;
      o_Idle     <= (state_nxt == RX_IDLE);
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: a serial driver queues the expected outcome of every frame,
// and a monitor pops and compares whenever the receiver pulses o_Valid or o_FrameErr.
module tb_uart_rx;

  logic        i_Clk = 1'b0;
  logic        i_Rst;
  logic        i_UART_RX;
  logic [15:0] i_ClksPerBit;
  logic        i_RxEn;
  logic [7:0]  o_Data;
  logic        o_Valid;
  logic        o_FrameErr;
  logic        o_Idle;

  uart_rx dut (
    .i_Clk        (i_Clk),
    .i_Rst        (i_Rst),
    .i_UART_RX    (i_UART_RX),
    .i_ClksPerBit (i_ClksPerBit),
    .i_RxEn       (i_RxEn),
    .o_Data       (o_Data),
    .o_Valid      (o_Valid),
    .o_FrameErr   (o_FrameErr),
    .o_Idle       (o_Idle)
  );

  always #5 i_Clk = ~i_Clk;

  typedef struct packed {
    logic       ferr;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] last_good;
  int         n_checks = 0;
  int         n_pass   = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endfunction

  // Frame outcome model: a high stop bit delivers the byte, a low one reports an error
  // and leaves the last good byte on o_Data.
  function automatic void expect_frame(input logic [7:0] b, input logic stopv);
    exp_t e;
    if (stopv) begin
      last_good = b;
      e.ferr    = 1'b0;
    end else begin
      e.ferr    = 1'b1;
    end
    e.data = last_good;
    exp_q.push_back(e);
  endfunction

  always @(negedge i_Clk) begin : monitor
    exp_t e;
    if (o_Valid || o_FrameErr) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 32'({o_Valid, o_FrameErr}), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind", 32'({o_Valid, o_FrameErr}), e.ferr ? 32'd1 : 32'd2);
        check("pulse_data", 32'(o_Data), 32'(e.data));
      end
    end
  end

  task automatic step();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic drive_bit(input logic v, input int cpb);
    i_UART_RX = v;
    repeat (cpb) step();
  endtask

  // rst_bit >= 0 aborts the frame with a reset pulse at that data bit; chg_bit >= 0 moves
  // i_ClksPerBit to 100 at that data bit while the line keeps the original timing.
  task automatic send(input logic [7:0] b, input int cpb, input logic stopv,
                      input int rst_bit, input int chg_bit);
    i_ClksPerBit = 16'(cpb);
    if (rst_bit < 0) expect_frame(b, stopv);
    drive_bit(1'b0, cpb);
    for (int i = 0; i < 8; i++) begin
      if (i == chg_bit) i_ClksPerBit = 16'd100;
      if (rst_bit >= 0 && i == rst_bit) begin
        i_UART_RX = 1'b1;
        i_Rst     = 1'b1;
        step();
        i_Rst     = 1'b0;
        last_good = 8'h00;
        check("rst_idle", 32'(o_Idle), 32'd1);
        check("rst_data", 32'(o_Data), 32'd0);
        check("rst_pulses", 32'({o_Valid, o_FrameErr}), 32'd0);
        repeat (cpb - 1) step();
      end else if (rst_bit >= 0 && i > rst_bit) begin
        drive_bit(1'b1, cpb);
      end else begin
        drive_bit(b[i], cpb);
      end
    end
    drive_bit(stopv, cpb);
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 5000) begin
      step();
      t++;
    end
    repeat (4) step();
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int   k;
    logic prev_ferr;
    logic stopv;
    int   cpb;
    int   gap;

    i_Rst        = 1'b1;
    i_UART_RX    = 1'b1;
    i_RxEn       = 1'b1;
    i_ClksPerBit = 16'd8;
    last_good    = 8'h00;
    repeat (3) step();
    check("reset_idle", 32'(o_Idle), 32'd1);
    check("reset_data", 32'(o_Data), 32'd0);
    check("reset_valid", 32'(o_Valid), 32'd0);
    check("reset_ferr", 32'(o_FrameErr), 32'd0);
    i_Rst = 1'b0;
    repeat (4) step();

    send(8'hA5, 8, 1'b1, -1, -1);
    drive_bit(1'b1, 16);
    drain("loopback_a5");

    // Bad stop bit, then a 100-bit break with the line held low.
    send(8'h3C, 8, 1'b0, -1, -1);
    repeat (800) step();
    drain("break_single_err");
    check("break_idle", 32'(o_Idle), 32'd1);
    drive_bit(1'b1, 16);
    send(8'h81, 8, 1'b1, -1, -1);
    drive_bit(1'b1, 16);
    drain("after_break_81");

    send(8'h00, 16, 1'b1, -1, -1);
    send(8'hFF, 16, 1'b1, -1, -1);
    drive_bit(1'b1, 32);
    drain("back_to_back");

    // Two-cycle glitch must be rejected at the half-bit check.
    i_ClksPerBit = 16'd16;
    i_UART_RX    = 1'b0;
    step();
    step();
    i_UART_RX = 1'b1;
    step();
    step();
    check("glitch_busy", 32'(o_Idle), 32'd0);
    k = 2;
    while (!o_Idle && k < 12) begin
      step();
      k++;
    end
    check("glitch_idle", 32'(o_Idle), 32'd1);
    repeat (40) step();
    drain("glitch_no_pulse");

    send(8'hC3, 8, 1'b1, -1, 2);
    i_ClksPerBit = 16'd8;
    drive_bit(1'b1, 16);
    drain("cpb_change_c3");

    send(8'hF0, 8, 1'b1, 4, -1);
    drive_bit(1'b1, 16);
    send(8'h5A, 8, 1'b1, -1, -1);
    drive_bit(1'b1, 16);
    drain("after_reset_5a");

    prev_ferr = 1'b0;
    for (int n = 0; n < 40; n++) begin
      cpb   = int'($urandom_range(4, 20));
      stopv = ($urandom_range(0, 9) != 0);
      gap   = prev_ferr ? int'($urandom_range(1, 3)) : int'($urandom_range(0, 3));
      if (gap > 0) drive_bit(1'b1, gap * cpb);
      send(8'($urandom), cpb, stopv, -1, -1);
      prev_ferr = !stopv;
    end
    drive_bit(1'b1, 40);
    drain("random_frames");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameters: none; bit timing comes only from the i_ClksPerBit port.
REQ-002 i_Clk  in  1  system clock; all logic on its rising edge.
REQ-003 i_Rst  in  1  synchronous, active-high reset.
REQ-004 i_UART_RX  in  1  asynchronous serial line; idle high; 8N1, LSB first.
REQ-005 i_ClksPerBit  in  16  i_Clk cycles per bit; supported range 4..65535; same encoding as the transmitter's i_ClksPerBit.
REQ-006 i_RxEn  in  1  high enables detection of new start bits.
REQ-007 o_Data  out  8  last correctly framed byte.
REQ-008 o_Valid  out  1  one-cycle pulse; o_Data updated in the same cycle.
REQ-009 o_FrameErr  out  1  one-cycle pulse; stop bit sampled low.
REQ-010 o_Idle  out  1  high when in RX_IDLE.

Function
REQ-011 i_UART_RX SHALL pass through a 2-flop synchronizer (both flops reset to 1); "rx" below means the synchronizer output.
REQ-012 States SHALL be RX_IDLE, RX_START, RX_DATA, RX_STOP, held in a 2-bit register.
REQ-013 RX_IDLE: counter=0, bit index=0, o_Idle=1; on i_RxEn=1 && armed && rx=0, latch i_ClksPerBit into r_Cpb, o_Idle<=0, go to RX_START.
REQ-014 armed SHALL be set whenever rx=1 is seen in RX_IDLE, cleared on frame error, and reset to 1.
REQ-015 RX_START: counter increments from 0 each cycle; at counter == (r_Cpb>>1)-1, sample rx.
- rx=0: counter<=0, go to RX_DATA.
- rx=1 (glitch): go to RX_IDLE with no pulse.
REQ-016 RX_DATA: at counter == r_Cpb-1, shift[bit index]<=rx, counter<=0, bit index++.
- After bit index 7 is sampled: bit index<=0, go to RX_STOP.
- Otherwise counter++.
REQ-017 RX_STOP: at counter == r_Cpb-1, sample rx.
- rx=1: o_Data<=shift, o_Valid<=1.
- rx=0: o_FrameErr<=1, o_Data unchanged, armed<=0.
- Either case: go to RX_IDLE.
REQ-018 o_Valid and o_FrameErr SHALL be high for exactly one cycle, never both, and low in every other cycle.
REQ-019 Latency: o_Valid SHALL rise one cycle after the stop-bit sample cycle; RX_IDLE is re-entered at mid-stop-bit, so a start bit immediately following the stop bit is captured.
REQ-020 Counters SHALL compare against the latched r_Cpb only; i_ClksPerBit changes mid-frame SHALL NOT affect the current frame.
REQ-021 i_RxEn deassertion mid-frame SHALL NOT abort the frame; it only blocks the next start detection.
REQ-022 A line held low (break) SHALL yield one o_FrameErr and then no further frames until rx returns high.
REQ-023 Counter arithmetic SHALL be 16-bit unsigned; (r_Cpb>>1)-1 >= 1 for the supported range.

Reset
REQ-024 On i_Rst, including mid-frame, next cycle:
- state=RX_IDLE, counters=0, shift=0;
- o_Data=8'h00, o_Valid=0, o_FrameErr=0, o_Idle=1;
- armed=1, synchronizer flops=1.
REQ-025 A frame interrupted by reset SHALL produce no pulse; reception restarts at the next valid falling edge.

Verification
REQ-026 Loopback from the transmitter, i_ClksPerBit=8, byte 0xA5 -> one o_Valid, o_Data=0xA5, no o_FrameErr.
REQ-027 Back-to-back 0x00 then 0xFF at i_ClksPerBit=16, no idle gap -> two o_Valid pulses with o_Data 0x00 then 0xFF.
REQ-028 Line low for 2 cycles at i_ClksPerBit=16 -> no pulse; o_Idle=1 again within 12 cycles.
REQ-029 0x3C with stop bit forced low, previous o_Data=0xA5 -> one o_FrameErr, o_Data stays 0xA5; line held low 100 bit times -> no further pulses; line released, then 0x81 -> o_Valid, o_Data=0x81.
REQ-030 i_Rst pulsed during bit 4 of a frame -> no pulse, o_Idle=1, o_Data=0x00; next frame 0x5A received correctly.
REQ-031 i_ClksPerBit changed 8->100 mid-frame for 0xC3 -> byte still received as 0xC3 at 8 clocks/bit.
